// File: rtl/morse_tone_player_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tone_player_if
//  Description : Request/status bundle between the character front end and
//                the Morse tone player. The front end is the master.
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_tone_player_if;
    logic       start;
    logic [4:0] sym_bits;
    logic [2:0] sym_len;
    logic [1:0] long_sel;
    logic [1:0] short_sel;
    logic       space_sel;
    logic       ready;
    logic       busy;
    logic       tone_on;
    logic       buzzer;
    logic       done;

    modport master (
        output start, sym_bits, sym_len, long_sel, short_sel, space_sel,
        input  ready, busy, tone_on, buzzer, done
    );

    modport slave (
        input  start, sym_bits, sym_len, long_sel, short_sel, space_sel,
        output ready, busy, tone_on, buzzer, done
    );
endinterface
`default_nettype wire

// File: rtl/morse_tone_player.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tone_player
//  Description : Plays one Morse character (up to five elements) as
//                tone-gated marks separated by silent gaps; flags completion
//                with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_tone_player #(
    parameter int UNIT_CYCLES = 20_000_000,
    parameter int TONE_HALF   = 50_000
) (
    input  wire logic               clk,
    input  wire logic               rst,
    morse_tone_player_if.slave      bus
);

    localparam int CNT_W  = $clog2(10 * UNIT_CYCLES + 1);
    localparam int HALF_W = $clog2(TONE_HALF + 1);

    localparam logic [CNT_W-1:0]  c_U1        = CNT_W'(1  * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_U3        = CNT_W'(3  * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_U4        = CNT_W'(4  * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_U5        = CNT_W'(5  * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_U8        = CNT_W'(8  * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_U10       = CNT_W'(10 * UNIT_CYCLES);
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);
    localparam logic [HALF_W-1:0] c_HALF_LAST = HALF_W'(TONE_HALF - 1);
    localparam logic [HALF_W-1:0] c_HALF_ONE  = HALF_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MARK = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state,  w_state;
    logic [CNT_W-1:0]    r_cnt,    w_cnt;
    logic [HALF_W-1:0]   r_half,   w_half;
    logic [2:0]          r_idx,    w_idx;
    logic [4:0]          r_bits,   w_bits;
    logic [2:0]          r_len,    w_len;
    logic [CNT_W-1:0]    r_long,   w_long;
    logic [CNT_W-1:0]    r_short,  w_short;
    logic [CNT_W-1:0]    r_space,  w_space;
    logic                r_ready,  w_ready;
    logic                r_busy,   w_busy;
    logic                r_tone,   w_tone;
    logic                r_buzzer, w_buzzer;
    logic                r_done,   w_done;

    logic [2:0]          w_len_clamp;
    logic [CNT_W-1:0]    w_long_dec;
    logic [CNT_W-1:0]    w_short_dec;
    logic [CNT_W-1:0]    w_space_dec;
    logic [CNT_W-1:0]    w_mark_cyc;

    // Decode the live select inputs into phase lengths in clock cycles.
    always_comb begin
        w_len_clamp = (bus.sym_len > 3'd5) ? 3'd5 : bus.sym_len;
        case (bus.long_sel)
            2'b10:   w_long_dec = c_U8;
            2'b11:   w_long_dec = c_U10;
            default: w_long_dec = c_U5;
        endcase
        case (bus.short_sel)
            2'b10:   w_short_dec = c_U3;
            2'b11:   w_short_dec = c_U4;
            default: w_short_dec = c_U1;
        endcase
        w_space_dec = bus.space_sel ? c_U5 : c_U3;
    end

    // Length of the current mark depends on the latched element type.
    assign w_mark_cyc = r_bits[r_idx] ? r_long : r_short;

    // Next-state and next-output logic; every output is the registered
    // version of a value computed here.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_half   = r_half;
        w_idx    = r_idx;
        w_bits   = r_bits;
        w_len    = r_len;
        w_long   = r_long;
        w_short  = r_short;
        w_space  = r_space;
        w_buzzer = r_buzzer;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_bits   = bus.sym_bits;
                    w_len    = w_len_clamp;
                    w_long   = w_long_dec;
                    w_short  = w_short_dec;
                    w_space  = w_space_dec;
                    w_idx    = 3'd0;
                    w_cnt    = '0;
                    w_half   = '0;
                    w_buzzer = 1'b0;
                    if (w_len_clamp == 3'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state = S_MARK;
                    end
                end
            end
            S_MARK: begin
                if (r_cnt == w_mark_cyc - c_CNT_ONE) begin
                    w_cnt    = '0;
                    w_half   = '0;
                    w_buzzer = 1'b0;
                    if (r_idx == r_len - 3'd1) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_GAP;
                    end
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                    if (r_half == c_HALF_LAST) begin
                        w_half   = '0;
                        w_buzzer = ~r_buzzer;
                    end else begin
                        w_half = r_half + c_HALF_ONE;
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == r_space - c_CNT_ONE) begin
                    w_cnt    = '0;
                    w_half   = '0;
                    w_buzzer = 1'b0;
                    w_idx    = r_idx + 3'd1;
                    w_state  = S_MARK;
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state  = S_IDLE;
                w_cnt    = '0;
                w_half   = '0;
                w_idx    = 3'd0;
                w_buzzer = 1'b0;
            end
        endcase

        w_ready = (w_state == S_IDLE);
        w_busy  = (w_state != S_IDLE);
        w_tone  = (w_state == S_MARK);
    end

    // State, counters, latched character and outputs; reset aborts silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_half   <= '0;
            r_idx    <= 3'd0;
            r_bits   <= 5'd0;
            r_len    <= 3'd0;
            r_long   <= '0;
            r_short  <= '0;
            r_space  <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_tone   <= 1'b0;
            r_buzzer <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_half   <= w_half;
            r_idx    <= w_idx;
            r_bits   <= w_bits;
            r_len    <= w_len;
            r_long   <= w_long;
            r_short  <= w_short;
            r_space  <= w_space;
            r_ready  <= w_ready;
            r_busy   <= w_busy;
            r_tone   <= w_tone;
            r_buzzer <= w_buzzer;
            r_done   <= w_done;
        end
    end

    assign bus.ready   = r_ready;
    assign bus.busy    = r_busy;
    assign bus.tone_on = r_tone;
    assign bus.buzzer  = r_buzzer;
    assign bus.done    = r_done;

endmodule
`default_nettype wire
